// File: rtl/config_frame_writer_pkg.sv
//==============================================================================
// Module      : config_frame_pkg
// Description : Shared types and constants for the configuration frame writer.
//               CONFIG_FRAME_CHECKSUM_EN adds the CHECK state.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package config_frame_pkg;

    localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

    localparam int HDR_COL_MSB   = 31;
    localparam int HDR_COL_LSB   = 24;
    localparam int HDR_FRAME_MSB = 4;
    localparam int HDR_FRAME_LSB = 0;

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
`ifdef CONFIG_FRAME_CHECKSUM_EN
        ST_CHECK  = 3'd3,
`endif
        ST_STROBE = 3'd4
    } cfw_state_t;

endpackage

`default_nettype wire

// File: rtl/config_frame_writer_if.sv
//==============================================================================
// Module      : config_frame_writer_if
// Description : Valid/ready word stream from the bitstream loader.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface config_frame_writer_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

`default_nettype wire

// File: rtl/frame_strobe_decoder.sv
//==============================================================================
// Module      : frame_strobe_decoder
// Description : Registered one-hot decode of (column, frame) onto FrameStrobe.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module frame_strobe_decoder #(
    parameter int NUM_COLUMNS        = 16,
    parameter int MAX_FRAMES_PER_COL = 20,
    parameter int COL_W              = 4,
    parameter int FRM_W              = 5
) (
    input  wire logic                                        clk,
    input  wire logic                                        rst,
    input  wire logic                                        i_en,
    input  wire logic [COL_W-1:0]                            i_col,
    input  wire logic [FRM_W-1:0]                            i_frame,
    output logic      [NUM_COLUMNS*MAX_FRAMES_PER_COL-1:0]   o_strobe
);

    localparam int c_width = NUM_COLUMNS * MAX_FRAMES_PER_COL;
    localparam int c_idx_w = $clog2(c_width);

    logic [c_idx_w-1:0] w_idx;
    logic [c_width-1:0] r_strobe;

    assign w_idx = c_idx_w'(i_col) * c_idx_w'(MAX_FRAMES_PER_COL) + c_idx_w'(i_frame);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_strobe <= '0;
        end else if (i_en) begin
            r_strobe <= {{(c_width-1){1'b0}}, 1'b1} << w_idx;
        end else begin
            r_strobe <= '0;
        end
    end

    assign o_strobe = r_strobe;

endmodule

`default_nettype wire

// File: rtl/config_frame_writer.sv
//==============================================================================
// Module      : config_frame_writer
// Description : Parses the configuration word stream into FrameData rows and
//               FrameStrobe pulses. CONFIG_FRAME_CHECKSUM_EN adds a per-frame
//               XOR checksum word.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module config_frame_writer
    import config_frame_pkg::*;
#(
    parameter int          NUM_ROWS           = 16,
    parameter int          NUM_COLUMNS        = 16,
    parameter int          FRAME_BITS_PER_ROW = 32,
    parameter int          MAX_FRAMES_PER_COL = 20,
    parameter logic [31:0] SYNC_PATTERN       = SYNC_WORD,
    parameter logic [31:0] DESYNC_PATTERN     = DESYNC_WORD
) (
    input  wire logic                                         CLK,
    input  wire logic                                         RST,
    config_frame_writer_if.slave                              s,
    output logic [NUM_ROWS*FRAME_BITS_PER_ROW-1:0]            FrameData,
    output logic [NUM_COLUMNS*MAX_FRAMES_PER_COL-1:0]         FrameStrobe,
    output logic                                              active,
    output logic                                              done,
    output logic                                              err
);

    localparam int c_row_w = $clog2(NUM_ROWS);
    localparam int c_col_w = $clog2(NUM_COLUMNS);
    localparam int c_frm_w = $clog2(MAX_FRAMES_PER_COL);

    cfw_state_t r_state, w_state_next;

    logic [FRAME_BITS_PER_ROW-1:0] r_rows [NUM_ROWS];
    logic [c_row_w-1:0]            r_row_cnt;
    logic [c_col_w-1:0]            r_col;
    logic [c_frm_w-1:0]            r_frame;
    logic                          r_active;
    logic                          r_done;
    logic                          r_err;

    logic                          w_accept;
    logic [7:0]                    w_hdr_col;
    logic [4:0]                    w_hdr_frame;
    logic                          w_hdr_bad;
    logic                          w_row_last;
    logic                          w_strobe_en;
    logic                          w_csum_bad;

    assign s.s_ready   = !RST && (r_state != ST_STROBE);
    assign w_accept    = s.s_valid && s.s_ready;
    assign w_hdr_col   = s.s_data[HDR_COL_MSB:HDR_COL_LSB];
    assign w_hdr_frame = s.s_data[HDR_FRAME_MSB:HDR_FRAME_LSB];
    assign w_hdr_bad   = (32'(w_hdr_col) >= 32'(NUM_COLUMNS)) ||
                         (32'(w_hdr_frame) >= 32'(MAX_FRAMES_PER_COL));
    assign w_row_last  = (r_row_cnt == c_row_w'(NUM_ROWS - 1));

`ifdef CONFIG_FRAME_CHECKSUM_EN
    logic [31:0] r_csum;
`endif

    always_comb begin
        w_state_next = r_state;
        w_strobe_en  = 1'b0;
        w_csum_bad   = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (w_accept && s.s_data == SYNC_PATTERN) w_state_next = ST_HEADER;
            end
            ST_HEADER: begin
                if (w_accept) begin
                    if (s.s_data == DESYNC_PATTERN || w_hdr_bad) w_state_next = ST_HUNT;
                    else                                         w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_accept && w_row_last) begin
`ifdef CONFIG_FRAME_CHECKSUM_EN
                    w_state_next = ST_CHECK;
`else
                    w_state_next = ST_STROBE;
                    w_strobe_en  = 1'b1;
`endif
                end
            end
`ifdef CONFIG_FRAME_CHECKSUM_EN
            ST_CHECK: begin
                if (w_accept) begin
                    if (s.s_data == r_csum) begin
                        w_state_next = ST_STROBE;
                        w_strobe_en  = 1'b1;
                    end else begin
                        w_state_next = ST_HEADER;
                        w_csum_bad   = 1'b1;
                    end
                end
            end
`endif
            ST_STROBE: w_state_next = ST_HEADER;
            default:   w_state_next = ST_HUNT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_HUNT;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_row_cnt <= '0;
            r_col     <= '0;
            r_frame   <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == ST_HEADER) && w_accept && (s.s_data == DESYNC_PATTERN);
            if (r_state == ST_HUNT && w_accept && s.s_data == SYNC_PATTERN) begin
                r_active <= 1'b1;
                r_err    <= 1'b0;
            end
            if (r_state == ST_HEADER && w_accept) begin
                if (s.s_data == DESYNC_PATTERN) begin
                    r_active <= 1'b0;
                end else if (w_hdr_bad) begin
                    r_active <= 1'b0;
                    r_err    <= 1'b1;
                end else begin
                    r_col     <= w_hdr_col[c_col_w-1:0];
                    r_frame   <= w_hdr_frame[c_frm_w-1:0];
                    r_row_cnt <= '0;
                end
            end
            // Counter parks on the last row; the next header rewinds it.
            if (r_state == ST_DATA && w_accept && !w_row_last) begin
                r_row_cnt <= r_row_cnt + 1'b1;
            end
            if (w_csum_bad) r_err <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_ROWS; i++) r_rows[i] <= '0;
        end else if (r_state == ST_DATA && w_accept) begin
            r_rows[r_row_cnt] <= s.s_data;
        end
    end

`ifdef CONFIG_FRAME_CHECKSUM_EN
    // Running XOR seeded with the header word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_csum <= '0;
        end else if (r_state == ST_HEADER && w_accept) begin
            r_csum <= s.s_data;
        end else if (r_state == ST_DATA && w_accept) begin
            r_csum <= r_csum ^ s.s_data;
        end
    end
`endif

    frame_strobe_decoder #(
        .NUM_COLUMNS        (NUM_COLUMNS),
        .MAX_FRAMES_PER_COL (MAX_FRAMES_PER_COL),
        .COL_W              (c_col_w),
        .FRM_W              (c_frm_w)
    ) u_strobe_dec (
        .clk      (CLK),
        .rst      (RST),
        .i_en     (w_strobe_en),
        .i_col    (r_col),
        .i_frame  (r_frame),
        .o_strobe (FrameStrobe)
    );

    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_rows
        assign FrameData[gi*FRAME_BITS_PER_ROW +: FRAME_BITS_PER_ROW] = r_rows[gi];
    end

    assign active = r_active;
    assign done   = r_done;
    assign err    = r_err;

endmodule

`default_nettype wire
